stack_frame_reverser: RTL and testbench
=======================================

// Module: stack_frame_reverser
// PURPOSE
//  Master-side controller for the team's push/pop LIFO stack: the LIFO is the storage
//  responder, and this block is the initiator that drives its push/pop port.
//  - Accepts a framed byte stream (valid/ready/last) and pushes each beat into the stack.
//  - Then pops the stack to emit the same frame in reversed order on a valid/ready/last
//    output stream.
//  - Sits between a packet source and a byte-reversed consumer, e.g. endian/bit-order
//    reversal of variable-length frames.
// PARAMETERS
//  WIDTH  8  data width; must equal the attached stack's WIDTH
//  DEPTH  8  stack depth; must equal the attached stack's DEPTH; maximum chunk length
// PORTS
//  clk        in   1      clock, rising edge
//  rstn       in   1      synchronous active-low reset; the attached stack shares it
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  in_data    in   WIDTH  input beat data
//  in_last    in   1      marks the final beat of the input frame
//  out_valid  out  1      output beat valid
//  out_ready  in   1      output beat consumed when out_valid & out_ready
//  out_data   out  WIDTH  output beat data, registered
//  out_last   out  1      marks the final beat of the reversed chunk
//  ovf_err    out  1      one-cycle pulse: chunk truncated at DEPTH without in_last
//  stk_push   out  1      stack push; stk_din is written in the same cycle
//  stk_pop    out  1      stack pop; stk_dout is valid from the next cycle
//  stk_din    out  WIDTH  data to the stack; combinational copy of in_data
//  stk_dout   in   WIDTH  registered stack output
//  stk_empty  in   1      stack empty flag, used for an assertion only
//  stk_full   in   1      stack full flag
// BEHAVIOUR
//  - Reset (rstn=0 at a clk edge):
//    - state=FILL, cnt=0.
//    - in_ready, out_valid, out_last, ovf_err, stk_push and stk_pop all 0.
//    - out_data=0.
//    - Reset mid-frame discards the partial frame; the stack resets with it.
//  - cnt: $clog2(DEPTH+1) bits, counts beats held in the stack. It never exceeds DEPTH
//    and never goes below 0.
//  - stk_push and stk_pop are never high in the same cycle.
//  - FILL:
//    - in_ready = !stk_full & (cnt<DEPTH).
//    - stk_push = in_valid & in_ready; on push, cnt+1.
//    - Push with in_last=1 -> POP.
//    - Push that makes cnt==DEPTH with in_last=0 -> POP, and ovf_err pulses for 1 cycle.
//      The remaining beats of the frame form the next chunk.
//  - POP: stk_pop=1 for exactly 1 cycle, cnt-1; -> LOAD.
//  - LOAD: out_data<=stk_dout, out_valid<=1, out_last<=(cnt==0); -> SEND.
//  - SEND:
//    - out_valid, out_data and out_last are held stable until out_ready=1.
//    - On handshake: out_valid<=0, out_last<=0; -> POP if cnt!=0, else FILL.
//  - Timing:
//    - Last push at edge N -> stk_pop in cycle N+1.
//    - First out_valid=1 from cycle N+3.
//    - Steady state is one output beat per 3 cycles with out_ready=1.
//  - Outside FILL: in_ready=0, and in_valid is ignored.
//  - In FILL: out_valid=0.
//  - Single-beat frame (in_last on the first beat): output one beat with out_last=1.
//  - Assertion: stk_empty is consistent with cnt==0 in every state.
// TESTING
//  1. Push 0x11,0x22,0x33,0x44 (last on 0x44), out_ready=1 -> out 0x44,0x33,0x22,0x11,
//     out_last only on 0x11, ovf_err stays 0.
//  2. Single beat 0xA5 with in_last=1 -> one output 0xA5, out_last=1; state returns to
//     FILL and in_ready=1 after the handshake.
//  3. DEPTH=8, 10-beat frame 0x01..0x0A (last on 0x0A):
//     - ovf_err pulses once after the 8th push.
//     - Out 0x08..0x01 with last on 0x01, then 0x0A,0x09 with last on 0x09.
//  4. Backpressure: out_ready=0 for 5 cycles during SEND -> out_valid=1 and out_data
//     stable; no stk_pop issued; order preserved after release.
//  5. Reset asserted in cycle 2 of drain, then released:
//     - All outputs 0 and in_ready=1.
//     - Next frame 0x77,0x88 -> out 0x88,0x77.
//  6. in_valid held high continuously across frames -> no beat accepted outside FILL;
//     no stk_push/stk_pop overlap, checked every cycle.

Source files
------------

// File: rtl/stack_frame_reverser.sv
// stack_frame_reverser: pushes a framed stream into an external LIFO, then
// pops it back out as a reversed valid/ready/last stream, one chunk at a time.
module stack_frame_reverser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             ovf_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_empty,
  input  logic             stk_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    FILL,
    POP,
    LOAD,
    SEND
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             rdy;
  logic             push;
  logic             pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;
    ovf_d   = 1'b0;
    rdy     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      FILL: begin
        rdy  = rstn & !stk_full & (cnt_q < CMAX);
        push = in_valid & rdy;
        if (push) begin
          cnt_d = cnt_q + 1'b1;
          // A full chunk without in_last is flushed; the rest follows.
          ovf_d = !in_last && (cnt_d == CMAX);
          if (in_last || (cnt_d == CMAX)) begin
            state_d = POP;
          end
        end
      end
      POP: begin
        pop     = rstn;
        state_d = LOAD;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOAD: begin
        data_d  = stk_dout;
        vld_d   = 1'b1;
        last_d  = (cnt_q == '0);
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          last_d  = 1'b0;
          state_d = (cnt_q != '0) ? POP : FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready  = rdy;
  assign stk_push  = push;
  assign stk_pop   = pop;
  assign stk_din   = in_data;
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign ovf_err   = ovf_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (stk_empty == (cnt_q == '0));
      assert (!(push && pop));
    end
  end

endmodule

// File: tb/tb_stack_frame_reverser.sv
// Bench for stack_frame_reverser: behavioural LIFO partner, queue-based
// frame-reversal model checked every cycle, plus literal output sequences.
module tb_stack_frame_reverser;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       ovf_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;
  logic       stk_empty;
  logic       stk_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_frame_reverser #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .ovf_err(ovf_err),
    .stk_push(stk_push),
    .stk_pop(stk_pop),
    .stk_din(stk_din),
    .stk_dout(stk_dout),
    .stk_empty(stk_empty),
    .stk_full(stk_full)
  );

  // LIFO responder
  logic [7:0] smem [0:DEPTH-1];
  logic [3:0] sp = 4'd0;
  logic [3:0] spm1;
  assign spm1      = sp - 4'd1;
  assign stk_empty = (sp == 4'd0);
  assign stk_full  = (sp == 4'd8);

  always @(posedge clk) begin
    if (!rstn) begin
      sp       <= 4'd0;
      stk_dout <= 8'd0;
    end else if (stk_push && !stk_full) begin
      smem[sp[2:0]] <= stk_din;
      sp            <= sp + 4'd1;
    end else if (stk_pop && !stk_empty) begin
      stk_dout <= smem[spm1[2:0]];
      sp       <= spm1;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Model state: pending reversed beats {last,data}, open chunk, log
  logic [8:0] exp_q[$];
  logic [7:0] chunk[$];
  logic [8:0] got[$];
  bit         ovf_pend = 0;
  int         lat_due = 0;
  bit         prev_hold = 0;
  logic [8:0] hold_v = '0;
  int         ovf_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      exp_q.delete();
      chunk.delete();
      ovf_pend  = 0;
      lat_due   = 0;
      prev_hold = 0;
    end else begin
      chk("push_pop_excl", 32'(stk_push & stk_pop), 0);
      chk("ovf_err", 32'(ovf_err), 32'(ovf_pend));
      if (ovf_err) ovf_cnt++;
      ovf_pend = 0;
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      if (in_ready) chk("fill_quiet", 32'({out_valid, stk_pop}), 0);
      if (out_valid) chk("send_no_pop", 32'(stk_pop), 0);
      if (prev_hold) chk("hold", 32'({out_valid, out_last, out_data}),
                         32'({1'b1, hold_v}));
      if (lat_due > 0) begin
        lat_due--;
        if (lat_due == 0) chk("latency", 32'(out_valid), 1);
        else chk("early_valid", 32'(out_valid), 0);
      end
      if (in_valid && in_ready) begin
        chk("push_strobe", 32'({stk_push, stk_din}), 32'({1'b1, in_data}));
        chunk.push_back(in_data);
        if (in_last || chunk.size() == DEPTH) begin
          for (int i = chunk.size() - 1; i >= 0; i--)
            exp_q.push_back({i == 0, chunk[i]});
          ovf_pend = !in_last;
          lat_due  = 3;
          chunk.delete();
        end
      end else begin
        chk("no_push", 32'(stk_push), 0);
      end
      if (out_valid && out_ready) begin
        got.push_back({out_last, out_data});
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'({out_last, out_data}), 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("out_beat", 32'({out_last, out_data}), 32'(e));
          if (!e[8]) lat_due = 3;
        end
      end
      prev_hold = out_valid && !out_ready;
      hold_v    = {out_last, out_data};
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d[$], input bit hold);
    foreach (d[i]) send_beat(d[i], i == d.size() - 1);
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic got_is(input string nm, input logic [8:0] e[$]);
    chk({nm, "_len"}, 32'(got.size()), 32'(e.size()));
    foreach (e[i])
      if (i < got.size()) chk({nm, "_seq"}, 32'(got[i]), 32'(e[i]));
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int o0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 32'({in_ready, out_valid, out_last, ovf_err,
                         stk_push, stk_pop, out_data}), 0);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    send_frame('{8'h11, 8'h22, 8'h33, 8'h44}, 0);
    wait_drain("t1");
    got_is("t1", '{9'h044, 9'h033, 9'h022, 9'h111});
    chk("t1_ovf", 32'(ovf_cnt), 0);

    send_frame('{8'hA5}, 0);
    wait_drain("t2");
    got_is("t2", '{9'h1A5});
    chk("t2_ready", 32'(in_ready), 1);

    o0 = ovf_cnt;
    send_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A}, 0);
    wait_drain("t3");
    got_is("t3", '{9'h008, 9'h007, 9'h006, 9'h005, 9'h004, 9'h003,
                   9'h002, 9'h101, 9'h00A, 9'h109});
    chk("t3_ovf", 32'(ovf_cnt - o0), 1);

    o0 = ovf_cnt;
    send_frame('{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8}, 0);
    wait_drain("t3b");
    got_is("t3b", '{9'h0C8, 9'h0C7, 9'h0C6, 9'h0C5, 9'h0C4, 9'h0C3,
                    9'h0C2, 9'h1C1});
    chk("t3b_ovf", 32'(ovf_cnt - o0), 0);

    out_ready = 1'b0;
    send_frame('{8'h31, 8'h32, 8'h33}, 0);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    chk("t4_valid", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold", 32'({out_valid, stk_pop, out_data}), 32'({2'b10, 8'h33}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("t4");
    got_is("t4", '{9'h033, 9'h032, 9'h131});

    send_frame('{8'h51, 8'h52, 8'h53, 8'h54}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst", 32'({in_ready, out_valid, out_last, ovf_err,
                       stk_push, stk_pop, out_data}), 0);
    rstn = 1'b1;
    #1;
    chk("t5_ready", 32'({in_ready, out_valid, out_last, out_data}),
        32'({1'b1, 10'd0}));
    got.delete();
    send_frame('{8'h77, 8'h88}, 0);
    wait_drain("t5");
    got_is("t5", '{9'h088, 9'h177});

    send_frame('{8'h61, 8'h62, 8'h63}, 1);
    send_frame('{8'h64}, 1);
    send_frame('{8'h65, 8'h66, 8'h67, 8'h68}, 0);
    wait_drain("t6");
    got_is("t6", '{9'h063, 9'h062, 9'h161, 9'h164,
                   9'h068, 9'h067, 9'h066, 9'h165});

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
